// File: rtl/phy_rx_lane_deskew.sv
// Two-lane receive deskew controller: tracks lane activity, measures the
// skew between COM sync bytes on both lanes and, once the skew has been
// seen LOCK_COUNT times in a row, drives the per-lane delay selects.
//
// state  | meaning
// IDLE   | a lane is inactive; all outputs held at 0
// HUNT   | waiting for the first complete COM pair
// CHECK  | confirming the recorded skew over consecutive pairs
// LOCKED | delay selects applied, lanes_aligned high
module phy_rx_lane_deskew #(
    parameter logic [7:0] COM_BYTE     = 8'hBC,
    parameter int         MAX_SKEW     = 3,
    parameter int         LOCK_COUNT   = 4,
    parameter int         LOSS_COUNT   = 4,
    parameter int         IDLE_TIMEOUT = 16
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] byte_in0,
    input  logic       valid_in0,
    input  logic [7:0] byte_in1,
    input  logic       valid_in1,
    output logic [1:0] dly_sel0,
    output logic [1:0] dly_sel1,
    output logic       lanes_aligned,
    output logic       active0,
    output logic       active1,
    output logic       skew_error
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [1:0]    MAX_K  = MAX_SKEW[1:0];
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_COUNT);
    localparam logic [LW-1:0] LOSS_N = LW'(LOSS_COUNT);
    localparam logic [IW-1:0] IDLE_N = IW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {IDLE, HUNT, CHECK, LOCKED} state_t;
    typedef enum logic [1:0] {EARLY_NONE, EARLY_L0, EARLY_L1} early_t;

    state_t        state_q;
    logic [CW-1:0] match_q;
    logic [LW-1:0] miss_q;
    logic [1:0]    skew_rec_q;
    early_t        early_rec_q;
    logic [1:0]    dly0_q, dly1_q;
    logic          aligned_q, err_q;

    logic          com0, com1;
    logic [IW-1:0] idle0_q, idle0_d, idle1_q, idle1_d;
    logic          act0_q, act0_d, act1_q, act1_d;
    logic          both_act_d, run;

    logic          pend_q, pend_d;
    logic          pend_lane_q, pend_lane_d;
    logic [1:0]    k_q, k_d;
    logic          own_com, oth_com;
    logic          pair_ev, tmo_ev, pair_match;
    logic [1:0]    pair_skew;
    early_t        pair_early;

    assign com0 = valid_in0 && (byte_in0 == COM_BYTE);
    assign com1 = valid_in1 && (byte_in1 == COM_BYTE);

    // Lane activity: COM sets a lane active, IDLE_TIMEOUT quiet cycles clear it.
    always_comb begin
        idle0_d = idle0_q;
        idle1_d = idle1_q;
        if (valid_in0)             idle0_d = '0;
        else if (idle0_q < IDLE_N) idle0_d = idle0_q + 1'b1;
        if (valid_in1)             idle1_d = '0;
        else if (idle1_q < IDLE_N) idle1_d = idle1_q + 1'b1;
        act0_d = com0 ? 1'b1 : ((idle0_d == IDLE_N) ? 1'b0 : act0_q);
        act1_d = com1 ? 1'b1 : ((idle1_d == IDLE_N) ? 1'b0 : act1_q);
    end

    assign both_act_d = act0_d && act1_d;
    assign run        = (state_q != IDLE) && both_act_d;

    // Register lane activity and idle counters.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            idle0_q <= '0;
            idle1_q <= '0;
            act0_q  <= 1'b0;
            act1_q  <= 1'b0;
        end else begin
            idle0_q <= idle0_d;
            idle1_q <= idle1_d;
            act0_q  <= act0_d;
            act1_q  <= act1_d;
        end
    end

    // Pair measurement: k_q holds the current cycle distance from the pending COM,
    // so a timeout fires in the cycle where k would step past MAX_SKEW.
    always_comb begin
        pair_ev     = 1'b0;
        tmo_ev      = 1'b0;
        pair_skew   = 2'd0;
        pair_early  = EARLY_NONE;
        pend_d      = pend_q;
        pend_lane_d = pend_lane_q;
        k_d         = k_q;
        own_com     = pend_lane_q ? com1 : com0;
        oth_com     = pend_lane_q ? com0 : com1;
        if (!pend_q) begin
            if (com0 && com1) begin
                pair_ev = 1'b1;
            end else if (com0) begin
                pend_d      = 1'b1;
                pend_lane_d = 1'b0;
                k_d         = 2'd1;
            end else if (com1) begin
                pend_d      = 1'b1;
                pend_lane_d = 1'b1;
                k_d         = 2'd1;
            end
        end else if (oth_com) begin
            pair_ev    = 1'b1;
            pair_skew  = k_q;
            pair_early = pend_lane_q ? EARLY_L1 : EARLY_L0;
            pend_d     = 1'b0;
            k_d        = 2'd0;
        end else if (own_com) begin
            k_d = 2'd1;
        end else if (k_q == MAX_K) begin
            tmo_ev = 1'b1;
            pend_d = 1'b0;
            k_d    = 2'd0;
        end else begin
            k_d = k_q + 2'd1;
        end
    end

    assign pair_match = pair_ev && (pair_skew == skew_rec_q) && (pair_early == early_rec_q);

    // Measurement engine state; held clear whenever the controller is idle.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_lane_q <= 1'b0;
            k_q         <= 2'd0;
        end else if (!run) begin
            pend_q      <= 1'b0;
            pend_lane_q <= 1'b0;
            k_q         <= 2'd0;
        end else begin
            pend_q      <= pend_d;
            pend_lane_q <= pend_lane_d;
            k_q         <= k_d;
        end
    end

    // Alignment FSM with registered outputs; a lane going inactive wins over pair events.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            match_q     <= '0;
            miss_q      <= '0;
            skew_rec_q  <= 2'd0;
            early_rec_q <= EARLY_NONE;
            dly0_q      <= 2'd0;
            dly1_q      <= 2'd0;
            aligned_q   <= 1'b0;
            err_q       <= 1'b0;
        end else if (!both_act_d) begin
            state_q   <= IDLE;
            match_q   <= '0;
            miss_q    <= '0;
            dly0_q    <= 2'd0;
            dly1_q    <= 2'd0;
            aligned_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (act0_q && act1_q) state_q <= HUNT;
                end
                HUNT: begin
                    if (pair_ev) begin
                        skew_rec_q  <= pair_skew;
                        early_rec_q <= pair_early;
                        match_q     <= CW'(1);
                        state_q     <= CHECK;
                    end else if (tmo_ev) begin
                        err_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (pair_match) begin
                        if (match_q + 1'b1 >= LOCK_N) begin
                            match_q   <= LOCK_N;
                            miss_q    <= '0;
                            state_q   <= LOCKED;
                            aligned_q <= 1'b1;
                            dly0_q    <= (early_rec_q == EARLY_L0) ? skew_rec_q : 2'd0;
                            dly1_q    <= (early_rec_q == EARLY_L1) ? skew_rec_q : 2'd0;
                        end else begin
                            match_q <= match_q + 1'b1;
                        end
                    end else if (pair_ev || tmo_ev) begin
                        err_q   <= 1'b1;
                        match_q <= '0;
                        state_q <= HUNT;
                    end
                end
                LOCKED: begin
                    if (pair_match) begin
                        miss_q <= '0;
                    end else if (pair_ev || tmo_ev) begin
                        err_q <= 1'b1;
                        if (miss_q + 1'b1 >= LOSS_N) begin
                            state_q   <= HUNT;
                            miss_q    <= '0;
                            match_q   <= '0;
                            dly0_q    <= 2'd0;
                            dly1_q    <= 2'd0;
                            aligned_q <= 1'b0;
                        end else begin
                            miss_q <= miss_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dly_sel0      = dly0_q;
    assign dly_sel1      = dly1_q;
    assign lanes_aligned = aligned_q;
    assign active0       = act0_q;
    assign active1       = act1_q;
    assign skew_error    = err_q;

endmodule

// File: tb/tb_phy_rx_lane_deskew.sv
// Directed bench for phy_rx_lane_deskew: lock at several skews, too-large
// skew, check mismatch, loss of lock, lane drop and asynchronous reset.
module tb_phy_rx_lane_deskew;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] FILL = 8'h55;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] byte_in0 = 8'h00, byte_in1 = 8'h00;
    logic       valid_in0 = 1'b0, valid_in1 = 1'b0;
    logic [1:0] dly_sel0, dly_sel1;
    logic       lanes_aligned, active0, active1, skew_error;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    phy_rx_lane_deskew dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .byte_in0      (byte_in0),
        .valid_in0     (valid_in0),
        .byte_in1      (byte_in1),
        .valid_in1     (valid_in1),
        .dly_sel0      (dly_sel0),
        .dly_sel1      (dly_sel1),
        .lanes_aligned (lanes_aligned),
        .active0       (active0),
        .active1       (active1),
        .skew_error    (skew_error)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic c0, input logic c1, input logic v0);
        byte_in0  = c0 ? COM : FILL;
        valid_in0 = v0 | c0;
        byte_in1  = c1 ? COM : FILL;
        valid_in1 = 1'b1;
        @(posedge clk_4f);
        #1;
        if (skew_error) err_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    // COM on the lead lane, partner COM 'skew' cycles later; returns right after the partner edge.
    task automatic pair(input int lead, input int skew);
        for (int i = 0; i <= skew; i++) begin
            if (lead == 0) step(i == 0, i == skew, 1'b1);
            else           step(i == skew, i == 0, 1'b1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
        err_seen = 0;
    endtask

    task automatic activate();
        step(1'b1, 1'b1, 1'b1);
        idle(2);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_dly0", dly_sel0, 0);
        chk("rst_dly1", dly_sel1, 0);
        chk("rst_aligned", lanes_aligned, 0);
        chk("rst_act0", active0, 0);
        chk("rst_act1", active1, 0);
        chk("rst_err", skew_error, 0);
        do_reset();

        // Zero skew
        step(1'b1, 1'b1, 1'b1);
        chk("z_act0", active0, 1);
        chk("z_act1", active1, 1);
        idle(2);
        for (int p = 0; p < 3; p++) begin pair(0, 0); idle(7); end
        chk("z_pre_aligned", lanes_aligned, 0);
        pair(0, 0);
        chk("z_aligned", lanes_aligned, 1);
        chk("z_dly0", dly_sel0, 0);
        chk("z_dly1", dly_sel1, 0);
        idle(4);
        chk("z_errs", err_seen, 0);

        // Lane 1 late by 2
        do_reset();
        activate();
        for (int p = 0; p < 4; p++) begin pair(0, 2); if (p < 3) idle(6); end
        chk("l1_aligned", lanes_aligned, 1);
        chk("l1_dly0", dly_sel0, 2);
        chk("l1_dly1", dly_sel1, 0);
        chk("l1_errs", err_seen, 0);

        // Skew too large: lane 0 five cycles after lane 1; each lone COM times out at k=4
        do_reset();
        activate();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i <= 5; i++) begin
                step(i == 5, i == 0, 1'b1);
                if (r == 0 && i == 2) chk("big_no_err_k3", skew_error, 0);
                if (r == 0 && i == 3) chk("big_err_k4", skew_error, 1);
            end
            idle(10);
        end
        chk("big_aligned", lanes_aligned, 0);
        chk("big_errs", err_seen, 6);

        // Check mismatch: skews 1,1,2 then four pairs at skew 2
        do_reset();
        activate();
        pair(0, 1); idle(7);
        pair(0, 1); idle(7);
        pair(0, 2);
        chk("mm_err", skew_error, 1);
        idle(1);
        chk("mm_err_pulse", skew_error, 0);
        idle(6);
        for (int p = 0; p < 3; p++) begin pair(0, 2); idle(6); end
        chk("mm_no_lock", lanes_aligned, 0);
        pair(0, 2);
        chk("mm_lock", lanes_aligned, 1);
        chk("mm_dly0", dly_sel0, 2);
        chk("mm_errs", err_seen, 1);

        // Loss of lock: lock at skew 1, then four pairs at skew 3
        do_reset();
        activate();
        for (int p = 0; p < 4; p++) begin pair(0, 1); idle(7); end
        chk("ll_lock_dly0", dly_sel0, 1);
        chk("ll_lock_aligned", lanes_aligned, 1);
        for (int p = 0; p < 3; p++) begin pair(0, 3); idle(5); end
        chk("ll_still_aligned", lanes_aligned, 1);
        chk("ll_still_dly0", dly_sel0, 1);
        pair(0, 3);
        chk("ll_err4", skew_error, 1);
        chk("ll_aligned", lanes_aligned, 0);
        chk("ll_dly0", dly_sel0, 0);
        chk("ll_dly1", dly_sel1, 0);
        idle(2);
        chk("ll_errs", err_seen, 4);

        // Lane drop: lock with lane 1 early by 2, then lane 0 goes quiet
        do_reset();
        activate();
        for (int p = 0; p < 4; p++) begin pair(1, 2); idle(6); end
        chk("ld_dly1", dly_sel1, 2);
        chk("ld_dly0", dly_sel0, 0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
        chk("ld_act0_15", active0, 1);
        chk("ld_aligned_15", lanes_aligned, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("ld_act0", active0, 0);
        chk("ld_act1", active1, 1);
        chk("ld_aligned", lanes_aligned, 0);
        chk("ld_dly1_clr", dly_sel1, 0);
        chk("ld_errs", err_seen, 0);

        // Relock, then assert reset in the middle of a pair
        activate();
        for (int p = 0; p < 4; p++) begin pair(0, 1); idle(7); end
        chk("ar_pre_aligned", lanes_aligned, 1);
        step(1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_dly0", dly_sel0, 0);
        chk("ar_dly1", dly_sel1, 0);
        chk("ar_aligned", lanes_aligned, 0);
        chk("ar_act0", active0, 0);
        chk("ar_act1", active1, 0);
        chk("ar_err", skew_error, 0);
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
        idle(3);
        chk("ar_post_aligned", lanes_aligned, 0);
        chk("ar_post_err", skew_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phy_rx_lane_deskew.md
Name: phy_rx_lane_deskew

Overview:
- Lane-alignment controller for the two-lane PHY receive path, in the clk_4f domain after the serial-to-parallel converters and before the 8:32 muxes.
- Watches both byte streams for the COM sync byte and measures inter-lane skew.
- Once the skew is stable, drives per-lane delay selects that set the lane delay lines, replacing fixed delays.
- Reports per-lane activity, an aligned flag and skew errors to the rest of the receiver.

Parameters:
- COM_BYTE, 8'hBC, sync byte used for alignment.
- MAX_SKEW, 3, largest correctable skew in clk_4f cycles; delay selects are 2 bits wide, so the maximum is 3.
- LOCK_COUNT, 4, consecutive matching COM pairs required to lock.
- LOSS_COUNT, 4, consecutive bad COM pairs that drop lock.
- IDLE_TIMEOUT, 16, consecutive cycles with valid low that deactivate a lane.

Ports:
- clk_4f  in  1  single clock; byte clock of both lanes.
- reset  in  1  asynchronous, active-high.
- byte_in0  in  8  lane 0 byte from serial-to-parallel.
- valid_in0  in  1  lane 0 byte valid.
- byte_in1  in  8  lane 1 byte from serial-to-parallel.
- valid_in1  in  1  lane 1 byte valid.
- dly_sel0  out  2  delay applied to lane 0, in cycles.
- dly_sel1  out  2  delay applied to lane 1, in cycles.
- lanes_aligned  out  1  high while the controller is LOCKED.
- active0  out  1  lane 0 active.
- active1  out  1  lane 1 active.
- skew_error  out  1  one-cycle pulse on a skew timeout or mismatch.

Behaviour:
- Reset, asynchronous: all outputs 0, FSM in IDLE, all counters 0, recorded skew 0.
- COM event, lane n: valid_inn=1 and byte_inn==COM_BYTE, sampled on the clk_4f rising edge.
- activen, all registered:
  - Set the cycle after a COM event on lane n.
  - Cleared after IDLE_TIMEOUT consecutive cycles with valid_inn=0.
  - Any valid byte resets the idle counter.
- Pair measurement engine, running in HUNT, CHECK and LOCKED:
  - COM on both lanes in the same cycle: pair complete, skew=0, early lane "none".
  - COM on one lane only: that lane becomes pending and counter k=0.
  - k increments each cycle while pending.
  - COM on the other lane at count k (1..MAX_SKEW): pair complete, skew=k, early lane = the pending lane.
  - COM on the pending lane again: restart k=0 with no error.
  - k exceeds MAX_SKEW with no partner: timeout event; pending clears.
- FSM:
  - IDLE: outputs held at 0. Go to HUNT when active0 and active1 are both 1.
  - HUNT: on the first complete pair, record skew and early lane, set match count=1, go to CHECK. A timeout pulses skew_error and stays in HUNT.
  - CHECK:
    - Pair equal to the record: increment match count.
    - Match count reaches LOCK_COUNT: go to LOCKED.
    - Differing pair or timeout: pulse skew_error, go to HUNT, clear match count.
  - LOCKED:
    - On entry, the early lane's dly_sel = recorded skew; the other lane's dly_sel = 0.
    - lanes_aligned=1 from the cycle after the LOCK_COUNT-th matching pair is detected.
    - Matching pair: clear the miss counter.
    - Differing pair or timeout: pulse skew_error and increment the miss counter.
    - Miss counter reaches LOSS_COUNT: go to HUNT; dly_sel0/1 and lanes_aligned go to 0 in the same cycle.
  - Any state: active0 or active1 falling sends the FSM to IDLE, clears dly_sel, lanes_aligned and all counters. This has priority over pair events in the same cycle.
- dly_sel0/1 change only on entering LOCKED or on leaving it. They are constant while LOCKED.
- skew_error is never asserted in IDLE.
- Counters saturate and never wrap.

Test Plan:
- Zero skew: reset, then COM on both lanes every 8 cycles, 4 times. Required: LOCKED; lanes_aligned=1 the cycle after the 4th pair; dly_sel0=0, dly_sel1=0; no skew_error.
- Lane 1 late by 2: lane 1 COM 2 cycles after lane 0, 4 pairs. Required: dly_sel0=2, dly_sel1=0, lanes_aligned=1.
- Skew too large: lane 0 COM 5 cycles after lane 1 (MAX_SKEW=3). Required: a skew_error pulse at k=4 each time; FSM stays in HUNT; lanes_aligned=0.
- Check mismatch: pairs with skew 1,1,2. Required: skew_error on the 3rd pair; return to HUNT; no lock until 4 equal pairs follow.
- Loss of lock: after locking at skew 1, send 4 pairs at skew 3. Required: skew_error pulses ×4; on the 4th, lanes_aligned=0 and dly_sel0=dly_sel1=0; FSM in HUNT.
- Lane drop and reset: while LOCKED, hold valid_in0=0 for 16 cycles. Required: active0=0, FSM in IDLE, lanes_aligned=0. Then assert reset mid-pair. Required: all outputs 0 immediately, asynchronously.
